// File: rtl/gaussian_pkg.sv
// Shared types and constants for the Gaussian window sequencer.
// Holds the sequencer state encoding and the row-buffer rotation helpers.
package gaussian_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int FILT_LAT   = 4;
  localparam int N_BUF      = 3;

  typedef enum logic [1:0] {
    FILL,
    FEED,
    DRAIN
  } state_e;

  typedef logic [1:0] buf_sel_t;

  // Row buffers rotate 0 -> 1 -> 2 -> 0.
  function automatic buf_sel_t sel_next(input buf_sel_t s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  function automatic buf_sel_t sel_prev(input buf_sel_t s);
    return (s == 2'd0) ? 2'd2 : s - 2'd1;
  endfunction

endpackage

// File: rtl/row_ram.sv
// One row buffer: single write port, single registered read port.
// The read register returns zero whenever no read is issued.
module row_ram
  import gaussian_pkg::*;
#(
  parameter  int DEPTH = 640,
  parameter  int DW    = DW_DEFAULT,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // NOTE: the storage array is deliberately left without reset so it maps onto
  // block RAM; only the read-data register is reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
    else           rdata_q <= '0;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/gaussian_window_ctrl.sv
// Row-buffering sequencer in front of a 3x3 Gaussian filter: fills three rotating
// row RAMs, bursts aligned rows into the filter and tags its interior outputs.
module gaussian_window_ctrl
  import gaussian_pkg::*;
#(
  parameter  int IMG_W = 640,
  parameter  int IMG_H = 480,
  parameter  int DW    = DW_DEFAULT,
  localparam int XW    = $clog2(IMG_W),
  localparam int YW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_pix,
  output logic          filt_en_o,
  output logic [DW-1:0] filt_d1_o,
  output logic [DW-1:0] filt_d2_o,
  output logic [DW-1:0] filt_d3_o,
  input  logic [DW-1:0] filt_pix_i,
  output logic          out_valid,
  output logic [DW-1:0] out_pix,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          frame_done
);

  localparam int            TAG_D    = FILT_LAT + 1;
  localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(IMG_H - 1);

  state_e        state_q;
  logic [XW-1:0] wcol_q, rcol_q;
  logic [YW-1:0] wrow_q, feed_row_q;
  buf_sel_t      wsel_q, top_sel_q;
  logic [2:0]    drain_q;
  logic          in_ready_q, filt_en_q, frame_done_q;

  logic          tag_v_q [TAG_D];
  logic [XW-1:0] tag_x_q [TAG_D];
  logic [YW-1:0] tag_y_q [TAG_D];

  logic          wr_beat, row_end, rd_en, tag_in;
  logic [DW-1:0] rdata [N_BUF];

  assign wr_beat = in_valid & in_ready_q;
  assign row_end = wr_beat & (wcol_q == COL_LAST);
  assign rd_en   = (state_q == FEED);
  assign tag_in  = rd_en & (rcol_q >= XW'(2));

  for (genvar b = 0; b < N_BUF; b++) begin : g_buf
    row_ram #(.DEPTH(IMG_W), .DW(DW)) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wr_beat && (wsel_q == buf_sel_t'(b))),
      .waddr_i (wcol_q),
      .wdata_i (in_pix),
      .re_i    (rd_en),
      .raddr_i (rcol_q),
      .rdata_o (rdata[b])
    );
  end

  // top_sel_q names the buffer holding the newest row r; older rows sit behind it.
  assign filt_d3_o = rdata[top_sel_q];
  assign filt_d2_o = rdata[sel_prev(top_sel_q)];
  assign filt_d1_o = rdata[sel_prev(sel_prev(top_sel_q))];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      wcol_q       <= '0;
      rcol_q       <= '0;
      wrow_q       <= '0;
      feed_row_q   <= '0;
      wsel_q       <= '0;
      top_sel_q    <= '0;
      drain_q      <= '0;
      in_ready_q   <= 1'b1;
      filt_en_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      filt_en_q    <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state_q)
        FILL: begin
          if (row_end) begin
            wcol_q     <= '0;
            wsel_q     <= sel_next(wsel_q);
            top_sel_q  <= wsel_q;
            feed_row_q <= wrow_q;
            if (wrow_q != ROW_LAST) wrow_q <= wrow_q + YW'(1);
            if (wrow_q >= YW'(2)) begin
              state_q    <= FEED;
              in_ready_q <= 1'b0;
              filt_en_q  <= 1'b1;
              rcol_q     <= '0;
            end
          end else if (wr_beat) begin
            wcol_q <= wcol_q + XW'(1);
          end
        end
        FEED: begin
          if (rcol_q == COL_LAST) begin
            state_q <= DRAIN;
            drain_q <= '0;
          end else begin
            rcol_q <= rcol_q + XW'(1);
          end
        end
        DRAIN: begin
          // frame_done lands on the final DRAIN cycle, with the last tagged output.
          if (drain_q == 3'(FILT_LAT - 1) && feed_row_q == ROW_LAST) frame_done_q <= 1'b1;
          if (drain_q == 3'(FILT_LAT)) begin
            state_q    <= FILL;
            in_ready_q <= 1'b1;
            if (feed_row_q == ROW_LAST) begin
              wrow_q <= '0;
              wcol_q <= '0;
              wsel_q <= '0;
            end
          end else begin
            drain_q <= drain_q + 3'd1;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  // Tag pipeline spans the RAM read cycle plus the filter latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAG_D; i++) begin
        tag_v_q[i] <= 1'b0;
        tag_x_q[i] <= '0;
        tag_y_q[i] <= '0;
      end
    end else begin
      tag_v_q[0] <= tag_in;
      tag_x_q[0] <= tag_in ? rcol_q - XW'(1) : '0;
      tag_y_q[0] <= tag_in ? feed_row_q - YW'(1) : '0;
      for (int i = 1; i < TAG_D; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_x_q[i] <= tag_x_q[i-1];
        tag_y_q[i] <= tag_y_q[i-1];
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign filt_en_o  = filt_en_q;
  assign frame_done = frame_done_q;
  assign out_valid  = tag_v_q[TAG_D-1];
  assign out_x      = tag_x_q[TAG_D-1];
  assign out_y      = tag_y_q[TAG_D-1];
  assign out_pix    = filt_pix_i;

endmodule

// File: tb/tb_gaussian_window_ctrl.sv
// Bench for gaussian_window_ctrl: three instances (6x5, 5x4, 3x3) with a behavioural
// 3x3 Gaussian filter; outputs are compared against image-level expectations.
module tb_gaussian_window_ctrl;

  localparam int NI   = 3;
  localparam int MAXN = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv  [NI];
  logic [7:0] ip  [NI];
  logic       ir  [NI];
  logic       fen [NI];
  logic       ov  [NI];
  logic       fd  [NI];
  logic [7:0] d1  [NI];
  logic [7:0] d2  [NI];
  logic [7:0] d3  [NI];
  logic [7:0] fp  [NI];
  logic [7:0] op  [NI];
  logic [7:0] ox  [NI];
  logic [7:0] oy  [NI];

  logic [2:0] ox0, oy0, ox1;
  logic [1:0] oy1, ox2, oy2;

  assign ox[0] = 8'(ox0);
  assign oy[0] = 8'(oy0);
  assign ox[1] = 8'(ox1);
  assign oy[1] = 8'(oy1);
  assign ox[2] = 8'(ox2);
  assign oy[2] = 8'(oy2);

  gaussian_window_ctrl #(.IMG_W(6), .IMG_H(5), .DW(8)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_pix(ip[0]),
    .filt_en_o(fen[0]), .filt_d1_o(d1[0]), .filt_d2_o(d2[0]), .filt_d3_o(d3[0]),
    .filt_pix_i(fp[0]), .out_valid(ov[0]), .out_pix(op[0]), .out_x(ox0), .out_y(oy0),
    .frame_done(fd[0]));

  gaussian_window_ctrl #(.IMG_W(5), .IMG_H(4), .DW(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_pix(ip[1]),
    .filt_en_o(fen[1]), .filt_d1_o(d1[1]), .filt_d2_o(d2[1]), .filt_d3_o(d3[1]),
    .filt_pix_i(fp[1]), .out_valid(ov[1]), .out_pix(op[1]), .out_x(ox1), .out_y(oy1),
    .frame_done(fd[1]));

  gaussian_window_ctrl #(.IMG_W(3), .IMG_H(3), .DW(8)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_pix(ip[2]),
    .filt_en_o(fen[2]), .filt_d1_o(d1[2]), .filt_d2_o(d2[2]), .filt_d3_o(d3[2]),
    .filt_pix_i(fp[2]), .out_valid(ov[2]), .out_pix(op[2]), .out_x(ox2), .out_y(oy2),
    .frame_done(fd[2]));

  function automatic int w_of(input int k);
    case (k)
      0:       return 6;
      1:       return 5;
      default: return 3;
    endcase
  endfunction

  function automatic int h_of(input int k);
    case (k)
      0:       return 5;
      1:       return 4;
      default: return 3;
    endcase
  endfunction

  // Behavioural filter: 3-column window, kernel [1 2 1]x[1 2 1]/16, output 4 cycles
  // after a column appears on d1..d3.
  logic [23:0] wc0 [NI];
  logic [23:0] wc1 [NI];
  logic [23:0] wc2 [NI];
  logic [7:0]  s1  [NI];
  logic [7:0]  s2  [NI];

  function automatic int colw(input logic [23:0] v);
    return int'(v[23:16]) + 2 * int'(v[15:8]) + int'(v[7:0]);
  endfunction

  function automatic logic [7:0] filt3(input logic [23:0] a, input logic [23:0] b,
                                       input logic [23:0] c);
    int s;
    s = colw(a) + 2 * colw(b) + colw(c);
    return 8'(s >> 4);
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        wc0[k] <= '0;
        wc1[k] <= '0;
        wc2[k] <= '0;
        s1[k]  <= '0;
        s2[k]  <= '0;
        fp[k]  <= '0;
      end else begin
        wc0[k] <= wc1[k];
        wc1[k] <= wc2[k];
        wc2[k] <= {d1[k], d2[k], d3[k]};
        s1[k]  <= filt3(wc0[k], wc1[k], wc2[k]);
        s2[k]  <= s1[k];
        fp[k]  <= s2[k];
      end
    end
  end

  // Image store and reference model.
  int img [2][8][8];
  int checks   = 0;
  int failures = 0;

  function automatic int gauss(input int f, input int x, input int y);
    int s;
    s = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        s += ((dx == 0) ? 2 : 1) * ((dy == 0) ? 2 : 1) * img[f][y+dy][x+dx];
    return s / 16;
  endfunction

  // Output monitor.
  int got_n    [NI];
  int got_x    [NI][MAXN];
  int got_y    [NI][MAXN];
  int got_p    [NI][MAXN];
  int got_fd   [NI][MAXN];
  int stray_fd [NI];
  int low_len  [NI];
  int runs_n   [NI];
  int runs_bad [NI];
  int ph       [NI];
  int cap_n    [NI];
  int cap_d1   [NI][MAXN];
  int cap_d2   [NI][MAXN];
  int cap_d3   [NI][MAXN];

  task automatic clear_mon();
    for (int k = 0; k < NI; k++) begin
      got_n[k] = 0; stray_fd[k] = 0; low_len[k] = 0; runs_n[k] = 0;
      runs_bad[k] = 0; ph[k] = 0; cap_n[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (ov[k] === 1'b1) begin
        if (got_n[k] < MAXN) begin
          got_x[k][got_n[k]]  = int'(ox[k]);
          got_y[k][got_n[k]]  = int'(oy[k]);
          got_p[k][got_n[k]]  = int'(op[k]);
          got_fd[k][got_n[k]] = int'(fd[k]);
        end
        got_n[k]++;
      end else if (fd[k] !== 1'b0) begin
        stray_fd[k]++;
      end
      if (ir[k] !== 1'b1) begin
        low_len[k]++;
      end else if (low_len[k] != 0) begin
        runs_n[k]++;
        if (low_len[k] != w_of(k) + 5) runs_bad[k]++;
        low_len[k] = 0;
      end
      if (ph[k] != 0) begin
        if (cap_n[k] < MAXN) begin
          cap_d1[k][cap_n[k]] = int'(d1[k]);
          cap_d2[k][cap_n[k]] = int'(d2[k]);
          cap_d3[k][cap_n[k]] = int'(d3[k]);
        end
        cap_n[k]++;
        ph[k] = (ph[k] == w_of(k)) ? 0 : ph[k] + 1;
      end else if (fen[k] === 1'b1) begin
        ph[k] = 1;
      end
    end
  end

  task automatic fill_ramp();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) img[0][y][x] = x + 10 * y;
  endtask

  task automatic fill_const(input int v);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) img[0][y][x] = v;
  endtask

  task automatic fill_rand(input bit same_second);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        img[0][y][x] = int'($urandom_range(0, 255));
        img[1][y][x] = same_second ? img[0][y][x] : int'($urandom_range(0, 255));
      end
  endtask

  // Drives n raster pixels (frames back to back); in_valid stays high unless gapped.
  task automatic drive(input int k, input int n, input bit gaps);
    int w, h, idx, cyc, f, p;
    w = w_of(k); h = h_of(k); idx = 0; cyc = 0;
    while (idx < n && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (gaps && $urandom_range(0, 99) < 30) begin
        iv[k] = 1'b0;
      end else begin
        f = idx / (w * h);
        p = idx % (w * h);
        iv[k] = 1'b1;
        ip[k] = 8'(img[f][p / w][p % w]);
        if (ir[k] === 1'b1) idx++;
      end
    end
    checks++;
    if (idx < n) begin
      failures++;
      $display("FAIL drive_timeout inst=%0d: accepted %0d pixels, required %0d", k, idx, n);
    end
    @(negedge clk);
    iv[k] = 1'b0;
  endtask

  task automatic check_outputs(input int k, input int nframes, input string name);
    int w, h, i, efd;
    w = w_of(k); h = h_of(k);
    checks++;
    if (got_n[k] !== nframes * (w - 2) * (h - 2)) begin
      failures++;
      $display("FAIL %s out_count: got %0d, expected %0d", name, got_n[k],
               nframes * (w - 2) * (h - 2));
    end
    i = 0;
    for (int f = 0; f < nframes; f++)
      for (int y = 1; y <= h - 2; y++)
        for (int x = 1; x <= w - 2; x++) begin
          if (i < got_n[k] && i < MAXN) begin
            efd = (y == h - 2 && x == w - 2) ? 1 : 0;
            checks++;
            if (got_x[k][i] !== x || got_y[k][i] !== y || got_p[k][i] !== gauss(f, x, y) ||
                got_fd[k][i] !== efd) begin
              failures++;
              $display("FAIL %s out[%0d]: got x=%0d y=%0d pix=%0d fd=%0d, expected x=%0d y=%0d pix=%0d fd=%0d",
                       name, i, got_x[k][i], got_y[k][i], got_p[k][i], got_fd[k][i],
                       x, y, gauss(f, x, y), efd);
            end
          end
          i++;
        end
    checks++;
    if (stray_fd[k] !== 0) begin
      failures++;
      $display("FAIL %s stray_frame_done: got %0d, expected 0", name, stray_fd[k]);
    end
    checks++;
    if (cap_n[k] !== nframes * (h - 2) * w) begin
      failures++;
      $display("FAIL %s feed_count: got %0d, expected %0d", name, cap_n[k], nframes * (h - 2) * w);
    end
    i = 0;
    for (int f = 0; f < nframes; f++)
      for (int r = 2; r < h; r++)
        for (int c = 0; c < w; c++) begin
          if (i < cap_n[k] && i < MAXN) begin
            checks++;
            if (cap_d1[k][i] !== img[f][r-2][c] || cap_d2[k][i] !== img[f][r-1][c] ||
                cap_d3[k][i] !== img[f][r][c]) begin
              failures++;
              $display("FAIL %s feed row=%0d col=%0d: got d1=%0d d2=%0d d3=%0d, expected %0d %0d %0d",
                       name, r, c, cap_d1[k][i], cap_d2[k][i], cap_d3[k][i],
                       img[f][r-2][c], img[f][r-1][c], img[f][r][c]);
            end
          end
          i++;
        end
    checks++;
    if (runs_n[k] !== nframes * (h - 2) || runs_bad[k] !== 0) begin
      failures++;
      $display("FAIL %s in_ready_low: got runs=%0d bad=%0d, expected runs=%0d bad=0 (len %0d)",
               name, runs_n[k], runs_bad[k], nframes * (h - 2), w + 5);
    end
  endtask

  task automatic check_reset_vals(input int k, input string name);
    checks++;
    if (ir[k] !== 1'b1 || fen[k] !== 1'b0 || ov[k] !== 1'b0 || fd[k] !== 1'b0) begin
      failures++;
      $display("FAIL %s ctrl inst=%0d: got ready=%b en=%b valid=%b done=%b, expected 1 0 0 0",
               name, k, ir[k], fen[k], ov[k], fd[k]);
    end
    checks++;
    if (d1[k] !== 8'd0 || d2[k] !== 8'd0 || d3[k] !== 8'd0) begin
      failures++;
      $display("FAIL %s filt_d inst=%0d: got %0d %0d %0d, expected 0 0 0", name, k, d1[k], d2[k], d3[k]);
    end
    checks++;
    if (ox[k] !== 8'd0 || oy[k] !== 8'd0) begin
      failures++;
      $display("FAIL %s coord inst=%0d: got x=%0d y=%0d, expected 0 0", name, k, ox[k], oy[k]);
    end
  endtask

  task automatic settle(input int k);
    repeat (w_of(k) + 15) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      iv[k] = 1'b0;
      ip[k] = 8'd0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) check_reset_vals(k, "reset");
    rst = 1'b0;
    @(posedge clk);
    #1 clear_mon();
  endtask

  task automatic test_constant();
    fill_const(100);
    @(posedge clk); #1 clear_mon();
    drive(1, 20, 1'b0);
    settle(1);
    check_outputs(1, 1, "constant");
  endtask

  task automatic test_ramp();
    fill_ramp();
    @(posedge clk); #1 clear_mon();
    drive(0, 30, 1'b0);
    settle(0);
    check_outputs(0, 1, "ramp");
  endtask

  task automatic test_gaps();
    fill_ramp();
    @(posedge clk); #1 clear_mon();
    drive(0, 30, 1'b1);
    settle(0);
    check_outputs(0, 1, "gaps");
  endtask

  task automatic test_back_to_back();
    fill_rand(1'b1);
    @(posedge clk); #1 clear_mon();
    drive(0, 60, 1'b0);
    settle(0);
    check_outputs(0, 2, "back_to_back");
  endtask

  task automatic test_reset_mid_feed();
    fill_rand(1'b0);
    @(posedge clk); #1 clear_mon();
    drive(0, 24, 1'b0);
    // Now in the first FEED cycle of row 3.
    checks++;
    if (ir[0] !== 1'b0 || fen[0] !== 1'b1) begin
      failures++;
      $display("FAIL feed_start: got ready=%b en=%b, expected 0 1", ir[0], fen[0]);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset_vals(0, "reset_mid_feed");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1 clear_mon();
    repeat (20) @(negedge clk);
    checks++;
    if (got_n[0] !== 0 || stray_fd[0] !== 0) begin
      failures++;
      $display("FAIL after_reset_quiet: got valid=%0d done=%0d, expected 0 0", got_n[0], stray_fd[0]);
    end
    fill_rand(1'b0);
    @(posedge clk); #1 clear_mon();
    drive(0, 30, 1'b0);
    settle(0);
    check_outputs(0, 1, "post_reset_frame");
  endtask

  task automatic test_min_size();
    fill_rand(1'b0);
    @(posedge clk); #1 clear_mon();
    drive(2, 9, 1'b0);
    settle(2);
    check_outputs(2, 1, "min_size");
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_gaps();
    test_back_to_back();
    test_reset_mid_feed();
    test_min_size();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
